// File: rtl/high_write_buffer_pkg.sv
// Shared definitions for the low-to-high write path inside bus_decode.
// The converters and the high write buffer all import this package, so they
// derive their widths from the same place.
//   - default parameter values for the wide-word path
//   - calc_high_width : wide data width from the low width and the burst log
//   - calc_entry_width: width of one buffered {addr, data} entry
//   - clog2           : ceiling log2 helper for sizing pointers
package high_write_buffer_pkg;

  localparam int DEFAULT_BRUST_SIZE_LOG = 2;
  localparam int DEFAULT_ADDR_WIDTH     = 16;
  localparam int DEFAULT_LOW_DATA_WIDTH = 8;
  localparam int DEFAULT_FIFO_DEPTH_LOG = 2;

  // One wide word is 2**burst_log low beats.
  function automatic int calc_high_width(input int low_width, input int burst_log);
    return low_width << burst_log;
  endfunction

  // The address is stored above the data in each entry.
  function automatic int calc_entry_width(input int addr_width, input int data_width);
    return addr_width + data_width;
  endfunction

  // Smallest n with 2**n >= value. Returns 1 for values of 1 or less so that
  // index ports never collapse to zero bits.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/high_write_buffer_if.sv
// Bus bundle between the low-to-high converter, the high write buffer and the
// wide memory port.
//   high_write_valid/data/addr : one-cycle pulse per assembled word (no ready)
//   mem_write_valid/data/addr  : head entry presented to the wide port
//   mem_write_ready            : sink accepts the head entry when high with valid
// Modports:
//   slave  - the buffer's view (consumes high_write_*, produces mem_write_*)
//   master - the environment's view (converter plus memory sink)
interface high_write_buffer_if #(
  parameter int ADDR_WIDTH      = 16,
  parameter int HIGH_DATA_WIDTH = 32
);

  logic [HIGH_DATA_WIDTH-1:0] high_write_data;
  logic [ADDR_WIDTH-1:0]      high_write_addr;
  logic                       high_write_valid;

  logic                       mem_write_valid;
  logic [HIGH_DATA_WIDTH-1:0] mem_write_data;
  logic [ADDR_WIDTH-1:0]      mem_write_addr;
  logic                       mem_write_ready;

  modport slave (
    input  high_write_data,
    input  high_write_addr,
    input  high_write_valid,
    output mem_write_valid,
    output mem_write_data,
    output mem_write_addr,
    input  mem_write_ready
  );

  modport master (
    output high_write_data,
    output high_write_addr,
    output high_write_valid,
    input  mem_write_valid,
    input  mem_write_data,
    input  mem_write_addr,
    output mem_write_ready
  );

endinterface

// File: rtl/high_write_buffer_fifo_mem.sv
// high_write_fifo_mem: parameterised register array backing the high write
// buffer. One synchronous write port and one asynchronous read port, which
// gives the buffer first-word fall-through on its output.
// Contents are deliberately not reset; the pointers decide what is valid.
//   clk     : write clock
//   wr_en   : write array[wr_addr] with wr_data on the rising edge
//   wr_addr : write index
//   wr_data : entry to store
//   rd_addr : read index
//   rd_data : combinational read of array[rd_addr]
module high_write_fifo_mem
  import high_write_buffer_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4,
  localparam int INDEX_WIDTH = clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [INDEX_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [INDEX_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]       rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write: no reset, so a reset never disturbs array contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/high_write_buffer.sv
// high_write_buffer: downstream stage of the low-to-high converter.
// It captures every wide word pulsed on high_write_*, queues it in a small
// FIFO and drains it to the wide port with a valid/ready handshake. The
// upstream side cannot be stalled, so a word that arrives while the FIFO is
// full and not draining is dropped, and a sticky overflow flag records it.
//   clk, rst       : clock and asynchronous active-high reset
//   bus            : slave side of high_write_buffer_if
//   fifo_count     : number of occupied entries (registered)
//   overflow       : sticky, set when a word was dropped
//   overflow_clear : synchronous clear of overflow (a drop in the same cycle wins)
module high_write_buffer
  import high_write_buffer_pkg::*;
#(
  parameter int BRUST_SIZE_LOG = DEFAULT_BRUST_SIZE_LOG,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int LOW_DATA_WIDTH = DEFAULT_LOW_DATA_WIDTH,
  parameter int FIFO_DEPTH_LOG = DEFAULT_FIFO_DEPTH_LOG
) (
  input  logic                    clk,
  input  logic                    rst,
  high_write_buffer_if.slave      bus,
  output logic [FIFO_DEPTH_LOG:0] fifo_count,
  output logic                    overflow,
  input  logic                    overflow_clear
);

  localparam int HIGH_DATA_WIDTH = calc_high_width(LOW_DATA_WIDTH, BRUST_SIZE_LOG);
  localparam int ENTRY_WIDTH     = calc_entry_width(ADDR_WIDTH, HIGH_DATA_WIDTH);
  localparam int DEPTH           = 1 << FIFO_DEPTH_LOG;
  localparam logic [FIFO_DEPTH_LOG:0] FULL_COUNT = (FIFO_DEPTH_LOG + 1)'(DEPTH);

  logic [FIFO_DEPTH_LOG-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG:0]   count;
  logic                      full;
  logic                      push;
  logic                      pop;
  logic                      drop;
  logic [ENTRY_WIDTH-1:0]    wr_entry;
  logic [ENTRY_WIDTH-1:0]    rd_entry;

  // A full FIFO can still take a word if the head leaves in the same cycle,
  // because the freed slot is the one the write pointer is about to reuse.
  always_comb begin
    full = (count == FULL_COUNT);
    pop  = bus.mem_write_valid & bus.mem_write_ready;
    push = bus.high_write_valid & (~full | pop);
    drop = bus.high_write_valid & full & ~pop;
  end

  assign wr_entry = {bus.high_write_addr, bus.high_write_data};

  high_write_fifo_mem #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr),
    .rd_data (rd_entry)
  );

  // Valid comes straight from the registered count, so it drops the instant
  // reset asserts and can only fall after a pop.
  assign bus.mem_write_valid = (count != '0);
  assign bus.mem_write_addr  = rd_entry[ENTRY_WIDTH-1 -: ADDR_WIDTH];
  assign bus.mem_write_data  = rd_entry[HIGH_DATA_WIDTH-1:0];
  assign fifo_count          = count;

  // Pointer and occupancy tracking. Pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_high_write_buffer.sv
// Directed self-checking bench for high_write_buffer at default parameters
// (32-bit data, 16-bit address, four entries). Inputs change 1 ns after the
// rising edge and outputs are checked at that same point, away from the edge.
module tb_high_write_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       overflow_clear;

  int checks = 0;
  int errors = 0;

  high_write_buffer_if #(.ADDR_WIDTH(16), .HIGH_DATA_WIDTH(32)) bus ();

  high_write_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .fifo_count     (fifo_count),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, take the rising edge, then return 1 ns later
  // with the pulse inputs released.
  task automatic applyStimulus(input logic push, input logic [31:0] data,
                               input logic [15:0] addr, input logic ready,
                               input logic clear);
    bus.high_write_valid = push;
    bus.high_write_data  = data;
    bus.high_write_addr  = addr;
    bus.mem_write_ready  = ready;
    overflow_clear       = clear;
    @(posedge clk);
    #1;
    bus.high_write_valid = 1'b0;
    bus.mem_write_ready  = 1'b0;
    overflow_clear       = 1'b0;
  endtask

  task automatic pushWord(input logic [31:0] data, input logic [15:0] addr);
    applyStimulus(1'b1, data, addr, 1'b0, 1'b0);
  endtask

  // Check the presented head entry, then accept it.
  task automatic popExpect(input string tag, input logic [31:0] data,
                           input logic [15:0] addr);
    checkOutput({tag, "_valid"}, 64'(bus.mem_write_valid), 64'd1);
    checkOutput({tag, "_data"},  64'(bus.mem_write_data),  64'(data));
    checkOutput({tag, "_addr"},  64'(bus.mem_write_addr),  64'(addr));
    applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
  endtask

  task automatic fillFour(input logic [31:0] base, input logic [15:0] addr0);
    for (int i = 0; i < 4; i++) begin
      pushWord(base * 32'(i + 1), addr0 + 16'(i));
      checkOutput($sformatf("fill_count%0d", i), 64'(fifo_count), 64'(i + 1));
    end
  endtask

  initial begin
    rst                  = 1'b1;
    bus.high_write_valid = 1'b0;
    bus.high_write_data  = '0;
    bus.high_write_addr  = '0;
    bus.mem_write_ready  = 1'b0;
    overflow_clear       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid",    64'(bus.mem_write_valid), 64'd0);
    checkOutput("reset_count",    64'(fifo_count),          64'd0);
    checkOutput("reset_overflow", 64'(overflow),            64'd0);
    rst = 1'b0;

    // Single word straight through.
    applyStimulus(1'b1, 32'hDEADBEEF, 16'h0010, 1'b1, 1'b0);
    checkOutput("single_count1", 64'(fifo_count), 64'd1);
    popExpect("single", 32'hDEADBEEF, 16'h0010);
    checkOutput("single_count0", 64'(fifo_count),          64'd0);
    checkOutput("single_valid0", 64'(bus.mem_write_valid), 64'd0);
    checkOutput("single_ovf",    64'(overflow),            64'd0);

    // Fill while the sink stalls; the head must hold.
    fillFour(32'h11111111, 16'h0000);
    applyStimulus(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    checkOutput("stall_data",  64'(bus.mem_write_data),  64'h11111111);
    checkOutput("stall_valid", 64'(bus.mem_write_valid), 64'd1);
    checkOutput("stall_count", 64'(fifo_count),          64'd4);
    for (int i = 0; i < 4; i++) begin
      popExpect($sformatf("drain%0d", i), 32'h11111111 * 32'(i + 1), 16'(i));
    end
    checkOutput("drain_valid0", 64'(bus.mem_write_valid), 64'd0);
    checkOutput("drain_count0", 64'(fifo_count),          64'd0);

    // Fifth word into a full, stalled FIFO is dropped.
    fillFour(32'h11111111, 16'h0000);
    pushWord(32'h55555555, 16'h0004);
    checkOutput("drop_ovf",   64'(overflow),           64'd1);
    checkOutput("drop_count", 64'(fifo_count),         64'd4);
    checkOutput("drop_head",  64'(bus.mem_write_data), 64'h11111111);
    for (int i = 0; i < 4; i++) begin
      popExpect($sformatf("dropdrain%0d", i), 32'h11111111 * 32'(i + 1), 16'(i));
    end
    checkOutput("dropdrain_valid0", 64'(bus.mem_write_valid), 64'd0);
    applyStimulus(1'b0, 32'h0, 16'h0, 1'b0, 1'b1);
    checkOutput("clear_ovf", 64'(overflow), 64'd0);

    // Full with a simultaneous pop: the new word lands in the wrapped slot.
    fillFour(32'h01010101, 16'h0020);
    applyStimulus(1'b1, 32'h66666666, 16'h0066, 1'b1, 1'b0);
    checkOutput("pushpop_count", 64'(fifo_count), 64'd4);
    checkOutput("pushpop_ovf",   64'(overflow),   64'd0);
    popExpect("wrap0", 32'h02020202, 16'h0021);
    popExpect("wrap1", 32'h03030303, 16'h0022);
    popExpect("wrap2", 32'h04040404, 16'h0023);
    popExpect("wrap3", 32'h66666666, 16'h0066);
    checkOutput("wrap_valid0", 64'(bus.mem_write_valid), 64'd0);

    // Clear in the same cycle as a drop: the drop wins.
    fillFour(32'h10101010, 16'h0040);
    applyStimulus(1'b1, 32'h99999999, 16'h0099, 1'b0, 1'b1);
    checkOutput("setwins_ovf", 64'(overflow), 64'd1);
    popExpect("setwins_head", 32'h10101010, 16'h0040);
    checkOutput("pre_reset_count", 64'(fifo_count), 64'd3);

    // Asynchronous reset with three entries held.
    rst = 1'b1;
    #1;
    checkOutput("async_valid",    64'(bus.mem_write_valid), 64'd0);
    checkOutput("async_count",    64'(fifo_count),          64'd0);
    checkOutput("async_overflow", 64'(overflow),            64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pushWord(32'h77777777, 16'h0077);
    checkOutput("post_reset_count", 64'(fifo_count), 64'd1);
    popExpect("post_reset", 32'h77777777, 16'h0077);
    checkOutput("post_reset_valid0", 64'(bus.mem_write_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
